// File: rtl/cfu_multi_dispatch.sv
// rtl/cfu_multi_dispatch.sv - CFU request fan-out to NUM_UNITS accelerators with in-order ID tracking and round-robin response merge
// Optional feature macro: CFU_DISPATCH_ILLEGAL_EN (error channel for unit selects >= NUM_UNITS).
module cfu_multi_dispatch #(
  parameter int NUM_UNITS       = 2,
  parameter int INSN_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SEL_LSB         = 25
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [INSN_W-1:0]           req_insn,
  input  logic [DATA_W-1:0]           req_data0,
  input  logic [DATA_W-1:0]           req_data1,
  input  logic [ID_W-1:0]             req_id,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_W-1:0]           resp_data,
  output logic [ID_W-1:0]             resp_id,
  output logic                        busy,
`ifdef CFU_DISPATCH_ILLEGAL_EN
  output logic                        err_illegal,
`endif
  output logic [NUM_UNITS-1:0]        u_req_valid,
  input  logic [NUM_UNITS-1:0]        u_req_ready,
  output logic [INSN_W-1:0]           u_req_insn,
  output logic [DATA_W-1:0]           u_req_data0,
  output logic [DATA_W-1:0]           u_req_data1,
  input  logic [NUM_UNITS-1:0]        u_resp_valid,
  output logic [NUM_UNITS-1:0]        u_resp_ready,
  input  logic [NUM_UNITS*DATA_W-1:0] u_resp_data
);

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int AW    = $clog2(MAX_OUTSTANDING);
  localparam int CW    = AW + 1;
`ifdef CFU_DISPATCH_ILLEGAL_EN
  localparam int NCH   = NUM_UNITS + 1;
`else
  localparam int NCH   = NUM_UNITS;
`endif
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;

  logic [SEL_W-1:0]     sel_raw;
  logic [SEL_W-1:0]     sel;
  logic                 sel_oob;
  logic [NUM_UNITS-1:0] sel_oh;
  logic [NUM_UNITS-1:0] full;
  logic [NUM_UNITS-1:0] empty;
  logic [NUM_UNITS-1:0] push;
  logic [NUM_UNITS-1:0] pop;
  logic [NCH-1:0]       elig;
  logic                 grant_valid;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        rr_ptr;
  logic [DATA_W-1:0]    gnt_data;
  logic [ID_W-1:0]      gnt_id;
  int                   cand;

  logic [ID_W-1:0] mem    [NUM_UNITS][MAX_OUTSTANDING];
  logic [AW-1:0]   wr_ptr [NUM_UNITS];
  logic [AW-1:0]   rd_ptr [NUM_UNITS];
  logic [CW-1:0]   count  [NUM_UNITS];

`ifdef CFU_DISPATCH_ILLEGAL_EN
  logic            err_valid;
  logic [ID_W-1:0] err_id;
  logic            err_push;
  logic            err_pop;
`endif

  assign sel_raw = req_insn[SEL_LSB +: SEL_W];
  assign sel_oob = ({1'b0, sel_raw} >= (SEL_W+1)'(NUM_UNITS));
`ifdef CFU_DISPATCH_ILLEGAL_EN
  // Out-of-range selects match no unit, so sel_oh stays all zero for them.
  assign sel = sel_raw;
`else
  assign sel = sel_oob ? SEL_W'(NUM_UNITS - 1) : sel_raw;
`endif

  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sel_oh[k] = (sel == SEL_W'(k));
      full[k]   = (count[k] == CW'(MAX_OUTSTANDING));
      empty[k]  = (count[k] == '0);
      elig[k]   = u_resp_valid[k] & ~empty[k];
    end
`ifdef CFU_DISPATCH_ILLEGAL_EN
    elig[NUM_UNITS] = err_valid;
`endif
  end

`ifdef CFU_DISPATCH_ILLEGAL_EN
  assign req_ready = sel_oob ? !err_valid : |(sel_oh & u_req_ready & ~full);
  assign err_push  = req_valid && req_ready && sel_oob;
  assign err_pop   = grant_valid && (grant_idx == PW'(NUM_UNITS));
`else
  assign req_ready = |(sel_oh & u_req_ready & ~full);
`endif

  assign u_req_valid = req_valid ? sel_oh : '0;
  assign u_req_insn  = req_insn;
  assign u_req_data0 = req_data0;
  assign u_req_data1 = req_data1;
  assign push        = (req_valid && req_ready) ? sel_oh : '0;

  // Round-robin search starting at rr_ptr; only when the output stage can take a result.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (!resp_valid || resp_ready) begin
      for (int i = 0; i < NCH; i++) begin
        cand = (int'(rr_ptr) + i) % NCH;
        if (!grant_valid && elig[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(cand);
        end
      end
    end
  end

  always_comb begin
    u_resp_ready = '0;
    gnt_data     = '0;
    gnt_id       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (grant_valid && grant_idx == PW'(k)) begin
        u_resp_ready[k] = 1'b1;
        gnt_data        = u_resp_data[k*DATA_W +: DATA_W];
        gnt_id          = mem[k][rd_ptr[k]];
      end
    end
`ifdef CFU_DISPATCH_ILLEGAL_EN
    if (err_pop) begin
      gnt_data = '1;
      gnt_id   = err_id;
    end
`endif
  end

  assign pop = u_resp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= req_id;
          wr_ptr[k]         <= wr_ptr[k] + 1'b1;
        end
        if (pop[k])
          rd_ptr[k] <= rd_ptr[k] + 1'b1;
        if (push[k] && !pop[k])
          count[k] <= count[k] + 1'b1;
        else if (pop[k] && !push[k])
          count[k] <= count[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (grant_valid) begin
      resp_valid <= 1'b1;
      resp_data  <= gnt_data;
      resp_id    <= gnt_id;
      rr_ptr     <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef CFU_DISPATCH_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid   <= 1'b0;
      err_id      <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (err_push) begin
        err_valid   <= 1'b1;
        err_id      <= req_id;
        err_illegal <= 1'b1;
      end else if (err_pop) begin
        err_valid <= 1'b0;
      end
    end
  end

  assign busy = |(~empty) | resp_valid | err_valid;
`else
  assign busy = |(~empty) | resp_valid;
`endif

endmodule

// File: tb/tb_cfu_multi_dispatch.sv
// tb/tb_cfu_multi_dispatch.sv - self-checking bench for cfu_multi_dispatch
module tb_cfu_multi_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_insn, req_data0, req_data1;
  logic [3:0]  req_id;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [3:0]  resp_id;
  logic        busy;
  logic [1:0]  u_req_valid, u_req_ready, u_resp_valid, u_resp_ready;
  logic [31:0] u_req_insn, u_req_data0, u_req_data1;
  logic [63:0] u_resp_data;
`ifdef CFU_DISPATCH_ILLEGAL_EN
  logic        err_illegal;
  logic        i3_req_ready, i3_resp_valid, i3_busy, i3_err;
  logic [31:0] i3_resp_data, i3_insn, i3_d0, i3_d1;
  logic [3:0]  i3_resp_id;
  logic [2:0]  i3_u_req_valid, i3_u_resp_ready;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          sel;
    logic        valid;
    logic [1:0]  ureadies;
    logic [31:0] d0;
    logic [1:0]  exp_uvalid;
    logic        exp_ready;
  } vec_t;
  vec_t vecs[6];

  cfu_multi_dispatch #(.NUM_UNITS(2), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
    .req_data0(req_data0), .req_data1(req_data1), .req_id(req_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy),
`ifdef CFU_DISPATCH_ILLEGAL_EN
    .err_illegal(err_illegal),
`endif
    .u_req_valid(u_req_valid), .u_req_ready(u_req_ready), .u_req_insn(u_req_insn),
    .u_req_data0(u_req_data0), .u_req_data1(u_req_data1),
    .u_resp_valid(u_resp_valid), .u_resp_ready(u_resp_ready), .u_resp_data(u_resp_data)
  );

`ifdef CFU_DISPATCH_ILLEGAL_EN
  cfu_multi_dispatch #(.NUM_UNITS(3), .MAX_OUTSTANDING(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(i3_req_ready), .req_insn(req_insn),
    .req_data0(req_data0), .req_data1(req_data1), .req_id(req_id),
    .resp_valid(i3_resp_valid), .resp_ready(resp_ready), .resp_data(i3_resp_data),
    .resp_id(i3_resp_id), .busy(i3_busy), .err_illegal(i3_err),
    .u_req_valid(i3_u_req_valid), .u_req_ready(3'b111), .u_req_insn(i3_insn),
    .u_req_data0(i3_d0), .u_req_data1(i3_d1),
    .u_resp_valid(3'b000), .u_resp_ready(i3_u_resp_ready), .u_resp_data(96'h0)
  );
`endif

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input int s, input logic [3:0] id);
    req_valid = v;
    req_insn  = {7'(s), 25'h0000033};
    req_id    = id;
  endtask

  // Checks the response handshake just before the rising edge, then queues any
  // expectation for a grant made in this cycle.
  task automatic tick(input logic push_exp, input logic [3:0] eid, input logic [31:0] edata);
    exp_t e;
    #2;
    if (sbq.size() > 0) chk("resp_valid_pending", resp_valid, 1'b1);
    if (resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got id %0h data %0h expected none", resp_id, resp_data);
      end else begin
        e = sbq.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_data", resp_data, e.data);
      end
    end
    if (push_exp) begin
      e.id   = eid;
      e.data = edata;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (resp_valid || sbq.size() > 0); i++) begin
      #1;
      tick(1'b0, 4'h0, 32'h0);
    end
    #1;
    chk("drained_resp_valid", resp_valid, 1'b0);
    chk("drained_queue", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 2'b11, 32'h1111, 2'b01, 1'b1};
    vecs[1] = '{1, 1'b1, 2'b11, 32'h2222, 2'b10, 1'b1};
    vecs[2] = '{0, 1'b1, 2'b10, 32'h3333, 2'b01, 1'b0};
    vecs[3] = '{1, 1'b1, 2'b01, 32'h4444, 2'b10, 1'b0};
    vecs[4] = '{0, 1'b0, 2'b11, 32'h5555, 2'b00, 1'b1};
    vecs[5] = '{1, 1'b0, 2'b00, 32'h6666, 2'b00, 1'b0};

    rst_n = 1'b0; resp_ready = 1'b1;
    u_resp_valid = 2'b11; u_resp_data = {32'hBEEF, 32'hCAFE};
    u_req_ready = 2'b11; req_data1 = 32'h77;
    drive_req(1'b0, 0, 4'h0); req_data0 = '0;
    @(negedge clk);

    // Routing table applied while reset holds the FIFOs empty.
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].valid, vecs[i].sel, 4'(i));
      u_req_ready = vecs[i].ureadies;
      req_data0   = vecs[i].d0;
      #1;
      chk("u_req_valid", 64'(u_req_valid), 64'(vecs[i].exp_uvalid));
      chk("req_ready", req_ready, vecs[i].exp_ready);
      chk("u_req_insn", u_req_insn, req_insn);
      chk("u_req_data0", u_req_data0, vecs[i].d0);
      chk("rst_u_resp_ready", 64'(u_resp_ready), 64'd0);
      tick(1'b0, 4'h0, 32'h0);
    end
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);

    rst_n = 1'b1; u_resp_valid = 2'b00; u_req_ready = 2'b11;
    drive_req(1'b0, 0, 4'h0);
    @(negedge clk);

    for (int i = 1; i <= 4; i++) begin
      drive_req(1'b1, 0, 4'(i));
      #1;
      chk("fill_ready", req_ready, 1'b1);
      tick(1'b0, 4'h0, 32'h0);
    end
    drive_req(1'b1, 0, 4'h5);
    #1;
    chk("full_blocks", req_ready, 1'b0);
    chk("busy_outstanding", busy, 1'b1);
    drive_req(1'b1, 1, 4'h7);
    #1;
    chk("other_unit_ready", req_ready, 1'b1);
    tick(1'b0, 4'h0, 32'h0);

    drive_req(1'b1, 0, 4'h5);
    u_resp_valid = 2'b11; u_resp_data = {32'hB0, 32'hA0};
    #1;
    chk("full_no_bypass", req_ready, 1'b0);
    chk("grant_u0", 64'(u_resp_ready), 64'b01);
    tick(1'b1, 4'h1, 32'hA0);

    u_resp_data = {32'hB1, 32'hA1};
    #1;
    chk("push_during_pop", req_ready, 1'b1);
    chk("grant_u1", 64'(u_resp_ready), 64'b10);
    tick(1'b1, 4'h7, 32'hB1);

    drive_req(1'b0, 0, 4'h0);
    u_resp_data = {32'hB2, 32'hA2};
    #1;
    chk("empty_unit_ineligible", 64'(u_resp_ready), 64'b01);
    tick(1'b1, 4'h2, 32'hA2);
    u_resp_data = {32'hB3, 32'hA3};
    #1;
    chk("grant_u0_again", 64'(u_resp_ready), 64'b01);
    tick(1'b1, 4'h3, 32'hA3);

    resp_ready = 1'b0; u_resp_data = {32'hB4, 32'hA4};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_no_grant", 64'(u_resp_ready), 64'b00);
      chk("stall_resp_id", 64'(resp_id), 64'h3);
      chk("stall_resp_data", resp_data, 32'hA3);
      tick(1'b0, 4'h0, 32'h0);
    end
    resp_ready = 1'b1;
    #1;
    chk("unstall_grant", 64'(u_resp_ready), 64'b01);
    tick(1'b1, 4'h4, 32'hA4);
    u_resp_data = {32'hB5, 32'hA5};
    #1;
    tick(1'b1, 4'h5, 32'hA5);
    u_resp_valid = 2'b00;
    drain();
    chk("idle_busy", busy, 1'b0);

    // Back-to-back results from one unit.
    drive_req(1'b1, 0, 4'h5); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 0, 4'h6); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b0, 0, 4'h0);
    u_resp_valid = 2'b01; u_resp_data = {32'h0, 32'hA};
    #1; tick(1'b1, 4'h5, 32'hA);
    u_resp_data = {32'h0, 32'hB};
    #1; tick(1'b1, 4'h6, 32'hB);
    u_resp_valid = 2'b00;
    drain();

    // Reset with an ID in flight discards it.
    drive_req(1'b1, 1, 4'hC); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b0, 0, 4'h0);
    #1;
    chk("busy_inflight", busy, 1'b1);
    rst_n = 1'b0;
    tick(1'b0, 4'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("reset_discards", busy, 1'b0);
    tick(1'b0, 4'h0, 32'h0);

    // Fairness with both units responding every cycle from pointer 0.
    drive_req(1'b1, 0, 4'h8); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 1, 4'hA); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 0, 4'h9); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 1, 4'hB); #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b0, 0, 4'h0);
    u_resp_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ids[4];
      ids = '{4'h8, 4'hA, 4'h9, 4'hB};
      u_resp_data = {32'hD0 + 32'(i), 32'hC0 + 32'(i)};
      #1;
      chk("rr_alternate", 64'(u_resp_ready), (i % 2 == 1) ? 64'b10 : 64'b01);
      tick(1'b1, ids[i], (i % 2 == 1) ? 32'hD0 + 32'(i) : 32'hC0 + 32'(i));
    end
    u_resp_valid = 2'b00;
    drain();
    chk("final_busy", busy, 1'b0);

`ifdef CFU_DISPATCH_ILLEGAL_EN
    rst_n = 1'b0; #1; tick(1'b0, 4'h0, 32'h0);
    rst_n = 1'b1; #1; tick(1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 3, 4'h9);
    #1;
    chk("ill_req_ready", i3_req_ready, 1'b1);
    chk("ill_no_unit", 64'(i3_u_req_valid), 64'd0);
    #2; @(negedge clk);
    drive_req(1'b0, 0, 4'h0);
    #1;
    chk("ill_err", i3_err, 1'b1);
    #2; @(negedge clk);
    #1;
    chk("ill_resp_valid", i3_resp_valid, 1'b1);
    chk("ill_resp_id", 64'(i3_resp_id), 64'h9);
    chk("ill_resp_data", i3_resp_data, 32'hFFFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfu_multi_dispatch.md
Name: cfu_multi_dispatch

Overview:
- Parametrised successor to the single-accelerator CFU wrapper. Fans one CFU request stream out to NUM_UNITS accelerator units, selected by an instruction field.
- Tracks outstanding request IDs in a per-unit in-order FIFO.
- Merges unit responses back onto the CFU response channel through a round-robin arbiter and a registered output stage.
- Sits between the CVA5 CFU port and the accelerator units (vector unit, crypto, etc.).

Parameters:
- NUM_UNITS, 2, number of accelerator units (1..8); SEL_W = max(1, $clog2(NUM_UNITS)) is derived.
- INSN_W, 32, instruction width.
- DATA_W, 32, operand/result width.
- ID_W, 4, CFU request ID width.
- MAX_OUTSTANDING, 4, per-unit ID FIFO depth (power of 2, >=2).
- SEL_LSB, 25, LSB of the unit-select field in req_insn.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  CFU request valid
- req_ready  out  1  CFU request ready
- req_insn  in  INSN_W  instruction
- req_data0  in  DATA_W  operand 0
- req_data1  in  DATA_W  operand 1
- req_id  in  ID_W  request ID
- resp_valid  out  1  CFU response valid
- resp_ready  in  1  CFU response accept
- resp_data  out  DATA_W  result
- resp_id  out  ID_W  ID of the result
- busy  out  1  any request outstanding
- u_req_valid  out  NUM_UNITS  per-unit request valid
- u_req_ready  in  NUM_UNITS  per-unit request ready
- u_req_insn  out  INSN_W  broadcast instruction
- u_req_data0  out  DATA_W  broadcast operand 0
- u_req_data1  out  DATA_W  broadcast operand 1
- u_resp_valid  in  NUM_UNITS  per-unit response valid
- u_resp_ready  out  NUM_UNITS  per-unit response accept
- u_resp_data  in  NUM_UNITS*DATA_W  unit k result in slice [k*DATA_W +: DATA_W]

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - All ID FIFOs empty; round-robin pointer = 0.
  - resp_valid=0, resp_data=0, resp_id=0, busy=0.
  - Applies mid-operation: in-flight IDs are discarded; units must be reset together with this block.
- Select: sel = req_insn[SEL_LSB +: SEL_W].
  - u_req_valid[sel] = req_valid; all other bits 0.
  - Insn and operands are broadcast combinationally.
- Request handshake:
  - req_ready = u_req_ready[sel] && !full[sel]. Combinational; no request register.
  - On req_valid && req_ready, req_id is pushed into FIFO[sel].
  - A full FIFO blocks its unit even if a pop occurs the same cycle (no bypass).
- Units return results in the order they accepted requests. FIFO[k] head is unit k's response ID.
- Response eligibility: unit k is eligible when u_resp_valid[k] && !empty[k].
  - If u_resp_valid[k] is asserted while FIFO[k] is empty, it is not eligible and u_resp_ready[k]=0.
- Arbiter:
  - Round-robin over eligible units, starting at the pointer.
  - Grant only when the output stage is free: !resp_valid || resp_ready.
  - On grant of k: u_resp_ready[k]=1 (one-hot, same cycle); FIFO[k] pops.
  - Next clock: resp_data <= slice k, resp_id <= FIFO[k] head, resp_valid <= 1, pointer <= (k+1) mod NUM_UNITS.
  - No grant: pointer holds.
- Latency and throughput:
  - 1 cycle from unit response to resp_valid.
  - Full throughput: 1 response/cycle while resp_ready=1.
- Output hold: when resp_valid && !resp_ready, resp_data and resp_id stay stable and no grant is made.
- Simultaneous push and pop on the same FIFO is legal; occupancy is unchanged.
- busy = OR over units of !empty[k], or resp_valid.

Optional Feature:
- Macro: CFU_DISPATCH_ILLEGAL_EN.
- Defined:
  - sel >= NUM_UNITS is illegal. The request is accepted when the internal one-entry error slot is empty; no unit sees it.
  - The slot holds req_id and competes in the arbiter as channel index NUM_UNITS, with the same round-robin rule.
  - The response carries resp_data = all ones.
  - Extra output err_illegal (1 bit) is set sticky on acceptance and cleared only by reset.
- Undefined:
  - sel >= NUM_UNITS is routed to unit NUM_UNITS-1.
  - No err_illegal port.

Test Plan:
- Reset: rst_n=0 for 2 cycles with u_resp_valid=all ones -> resp_valid=0, busy=0, u_resp_ready=0.
- NUM_UNITS=2, MAX_OUTSTANDING=4: send ids 1,2,3,4 to unit 0 with unit 0 not responding -> 5th request to unit 0 sees req_ready=0; a request to unit 1 is still accepted.
- Unit 0 returns data 0xA,0xB for ids 5,6 -> resp (5,0xA), then (6,0xB) on consecutive cycles, each 1 cycle after the unit response.
- Both units respond every cycle, resp_ready=1, pointer=0 -> grants alternate 0,1,0,1; no unit is starved.
- resp_ready=0 for 3 cycles with a response pending -> resp_data and resp_id stable; u_resp_ready=0 for all units; drains after resp_ready=1.
- CFU_DISPATCH_ILLEGAL_EN, NUM_UNITS=3, sel=3, id=9 -> resp (9,0xFFFFFFFF); err_illegal=1; no u_req_valid asserted.
